seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector with a Moore output. It generalises the team's fixed "101" Moore detector to a runtime-loadable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, a valid-qualified input stream and a saturating match counter. It sits on a serial bit stream, for example after a deserialiser or UART bit sampler, and flags sync words or frame markers.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (≥2)
LEN_W, 4, width of cfg_len; must hold the value MAX_LEN
CNT_W, 8, width of match_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  detector enable
cfg_we  in  1  load configuration this cycle
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
din_valid  in  1  din is a valid bit this cycle
din  in  1  serial data bit
dout  out  1  Moore match flag, registered
match_count  out  CNT_W  number of matches, saturating
state_o  out  2  current state (debug): 00 IDLE, 01 RUN, 10 HIT

Behaviour:
- Reset: asynchronous, active-high; clock clk.
- Reset values:
  - state RUN
  - pattern = 3'b101 zero-extended
  - len = 3
  - overlap = 1
  - history = 0, fill = 0
  - dout = 0, match_count = 0
- Reset behaviour equals the legacy 101 detector with a one-cycle registered output.
- Config load (cfg_we=1, any state):
  - Registers pattern and mode.
  - cfg_len is clamped: 0 → 1; values > MAX_LEN → MAX_LEN.
  - Clears history, fill and match_count.
  - Next state is RUN if en=1, else IDLE.
  - cfg_we has priority: a din_valid in the same cycle is discarded.
- History: MAX_LEN-bit shift register, {hist[MAX_LEN-2:0], din}, shifted only on accepted bits (din_valid=1, en=1, cfg_we=0).
- Fill counter: counts accepted bits and saturates at MAX_LEN.
- Match (combinational, on an accepted bit): (fill+1 ≥ len) AND the low len bits of {hist,din} equal the low len bits of pattern. Bits above len are ignored.
- On a match:
  - match_count increments, saturating at all-ones.
  - If overlap=0, fill resets to 0, so the next match needs len fresh bits. History is still shifted.
  - If overlap=1, fill is unchanged.
- FSM, evaluated each cycle when cfg_we=0:
  - IDLE: dout=0. When en=1, go to RUN. History and fill are held.
  - RUN: dout=0. On a match, go to HIT. When en=0, go to IDLE.
  - HIT: dout=1. On a match this cycle, stay in HIT. Otherwise go to RUN. When en=0, go to IDLE; en=0 takes priority over a match.
- dout is decoded from the state register only (Moore).
- Latency: dout rises in the cycle after the clock edge that accepted the completing bit.
  - One match gives exactly a one-cycle pulse.
  - Back-to-back matches (e.g. len=1) hold dout high continuously.
- din_valid gaps: no shift and no fill change. HIT still returns to RUN, so the pulse stays one cycle. Partial progress is retained across gaps.
- en deassert: drops to IDLE with dout=0 on the next edge. Progress is preserved and resumes on re-enable.
- Reset mid-operation: dout and match_count go to 0 immediately (asynchronously) and the default 101 configuration is restored.
- Unused state encoding 11 recovers to RUN on the next edge with dout=0.
- Synthesisable, single clock domain, no latches.

Test Plan:
1. Defaults after rst; en=1; stream 1,0,1,0,1 with din_valid every cycle → dout pulses one cycle after the 3rd and 5th bits; match_count=2.
2. cfg_we with pattern=101, len=3, overlap=0; same stream 1,0,1,0,1 → single pulse after the 3rd bit; match_count=1; a further 0,1 gives a second pulse (count=2).
3. cfg_we with pattern=1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 → pulses after bit 4 and bit 7; count=2. With cfg_len=15 (LEN_W=4, MAX_LEN=8): len clamps to 8.
4. Default config; bits 1,0,1 each separated by 3 cycles of din_valid=0 → one dout pulse, exactly one cycle wide, one cycle after the final 1. Toggling en=0 mid-pattern then back to 1 still detects on completion.
5. len=1, pattern=1, CNT_W=2; stream 1,1,1,1,1 → dout high 5 consecutive cycles; match_count saturates at 3.
6. Assert rst asynchronously while in HIT → dout=0 and match_count=0 before the next edge. Assert cfg_we together with din_valid=1, din=1 → bit dropped and fill=0.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bus bundle for seq_detect_prog: enable, configuration, serial input and
// match outputs. The master drives the stream; the slave is the detector.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               dout;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state_o;

    modport master (
        output en, cfg_we, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        input  dout, match_count, state_o
    );

    modport slave (
        input  en, cfg_we, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        output dout, match_count, state_o
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (Moore). Resets into the legacy
// overlapping "101" detector; patterns of 1..MAX_LEN bits load at runtime.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_prog_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               match;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   len_clamped;

    always_comb begin
        // IDLE holds history and fill, so bits only land in RUN/HIT
        accept   = bus.din_valid && bus.en && !bus.cfg_we && (state_q != IDLE);
        shifted  = {hist_q[MAX_LEN-2:0], bus.din};
        fill_inc = {1'b0, fill_q} + 1'b1;
        mask     = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        match = accept && (fill_inc >= {1'b0, len_q})
                && (((shifted ^ pattern_q) & mask) == '0);

        len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;

        if (bus.cfg_we) begin
            pattern_d = bus.cfg_pattern;
            len_d     = len_clamped;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            cnt_d     = '0;
            state_d   = bus.en ? RUN : IDLE;
        end else begin
            if (accept) begin
                hist_d = shifted;
                if (match && !overlap_q) begin
                    fill_d = '0;
                end else if (fill_q != LEN_W'(MAX_LEN)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: if (bus.en) state_d = RUN;
                RUN: begin
                    if (!bus.en)    state_d = IDLE;
                    else if (match) state_d = HIT;
                end
                HIT: begin
                    if (!bus.en)    state_d = IDLE;
                    else if (match) state_d = HIT;
                    else            state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pattern_q <= MAX_LEN'(3'b101);
            len_q     <= LEN_W'(3);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dout        = (state_q == HIT);
    assign bus.match_count = cnt_q;
    assign bus.state_o     = state_q;
endmodule
